steer_split: RTL and testbench
==============================

Name: steer_split

Overview:
- Downstream neighbour of the arbiter stage. Consumes the merged data token stream (out_data) and the matching decision token stream (chose_right).
- Routes each data token to left_out or right_out according to its paired decision token, so that arbitrated traffic can be split back into two streams.
- The decision stream is decoupled through a small control FIFO. Each branch output is registered, with per-branch stall isolation.

Parameters:
- W, 8, payload width. Data tokens are W+1 bits: bit W is valid, bits [W-1:0] are the payload.
- CDEPTH, 4, control FIFO depth in decision tokens. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_data  in  W+1  merged data token; bit W is valid.
- in_back_stop  out  1  stop to the data producer.
- sel  in  2  decision token; bit1 is valid, bit0 = 1 selects right.
- sel_back_stop  out  1  stop to the decision producer.
- left_out  out  W+1  data token for the left branch.
- left_stop  in  1  stop from the left consumer.
- right_out  out  W+1  data token for the right branch.
- right_stop  in  1  stop from the right consumer.

Behaviour:
- Transfer rule (every interface): a token moves when valid=1 and stop=0 in the same cycle. A producer seeing stop=1 holds its token unchanged.
- Reset (async, on rst_n=0):
  - control FIFO empty, count=0, pointers=0;
  - left_out=0 and right_out=0 (valid bits clear);
  - sel_back_stop=0;
  - in_back_stop=1 (FIFO empty).
- Control FIFO:
  - Push when sel[1]=1 and sel_back_stop=0.
  - sel_back_stop = (count==CDEPTH), registered.
  - Pop on a data fire.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo CDEPTH.
  - A pushed entry is visible at the head the next cycle, so minimum decision-to-use latency is 1 cycle.
- Head decision h = FIFO head bit0, valid when count>0.
- Target register T = right_out when h=1, left_out when h=0.
- T is free when T.valid=0, or when T.valid=1 and its stop=0 (draining this cycle).
- in_back_stop = (count==0) OR NOT T_free. This is combinational from left_stop/right_stop and the FIFO head.
- fire = in_data[W] AND NOT in_back_stop. On fire:
  - T loads in_data (valid=1) at the next edge;
  - FIFO pops.
  - Data latency is 1 cycle, in-order per branch.
- Output register: if it drains (valid and stop=0) and is not reloaded, its valid clears to 0. It holds its payload while its stop=1.
- Branch isolation: a stalled right_out blocks only tokens whose head decision is right. A stalled branch blocks the whole in_data stream at that point, because order is preserved.
- Full throughput: one token per cycle is sustained while the target stop=0 and the FIFO is non-empty.
- Simultaneous events:
  - FIFO at count=1 with push and pop together → count stays 1, and the new head is the pushed value.
  - Full FIFO: no push is accepted even if a pop occurs that cycle.
- Reset mid-operation: all queued decisions and buffered tokens are discarded; nothing is emitted after rst_n rises until new tokens arrive.

Optional Feature:
- Macro: STEER_SPLIT_COUNT_EN.
- When defined: adds ports left_cnt (out, 16) and right_cnt (out, 16).
  - Each counter increments on every fire to its branch.
  - Counters wrap at 16'hFFFF→0 and reset to 0 asynchronously.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with in_data valid → left_out=0, right_out=0, in_back_stop=1, sel_back_stop=0. Release reset → no output appears until a sel token arrives.
- Basic routing: push sel=2'b10 then 2'b11; present data 0xA5 then 0x3C, stops=0 → left_out=0x1A5 one cycle after the first fire, right_out=0x13C one cycle after the second.
- Backpressure: right_stop=1 with head=right and data 0x55 queued → right_out holds 0x155. After that token is captured and the next head is also right, in_back_stop=1 until right_stop=0; the next token follows 1 cycle later, with no loss or duplication.
- FIFO full: push 4 sel tokens (CDEPTH=4) with in_data invalid → sel_back_stop=1 at count 4. Present one data token → pop, and sel_back_stop=0 the following cycle.
- Streaming: alternating L/R sel, 16 back-to-back data tokens, stops=0 → one token out per cycle, order preserved per branch. With STEER_SPLIT_COUNT_EN defined: left_cnt=8, right_cnt=8.
- Async reset mid-stream: drop rst_n with 3 decisions queued and left_out valid → outputs clear immediately; after release, the old decisions are not reused.

Source files
------------

// File: rtl/steer_split.sv
// ============================================================================
// steer_split : routes each merged data token to left_out or right_out using
// a decision token queued in a small control FIFO; per-branch output regs.
// Optional macro STEER_SPLIT_COUNT_EN adds per-branch fire counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module steer_split #(
  parameter int W      = 8,
  parameter int CDEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W:0]   in_data,
  output logic         in_back_stop,
  input  logic [1:0]   sel,
  output logic         sel_back_stop,
  output logic [W:0]   left_out,
  input  logic         left_stop,
  output logic [W:0]   right_out,
  input  logic         right_stop
`ifdef STEER_SPLIT_COUNT_EN
  ,
  output logic [15:0]  left_cnt,
  output logic [15:0]  right_cnt
`endif
);

  localparam int c_AW = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
  localparam int c_CW = $clog2(CDEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(CDEPTH);

  logic              r_mem [CDEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              r_sel_bs;
  logic [W:0]        r_left;
  logic [W:0]        r_right;

  logic              w_push;
  logic              w_head;
  logic              w_tgt_free;
  logic              w_ibs;
  logic              w_fire;
  logic [c_CW-1:0]   w_count_nxt;

  assign w_push     = sel[1] && !r_sel_bs;
  assign w_head     = r_mem[r_rd_ptr];
  // A target register is free if empty or draining in this very cycle.
  assign w_tgt_free = w_head ? (!r_right[W] || !right_stop)
                             : (!r_left[W]  || !left_stop);
  assign w_ibs      = (r_count == '0) || !w_tgt_free;
  assign w_fire     = in_data[W] && !w_ibs;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_fire)      w_count_nxt = r_count + c_CW'(1);
    else if (!w_push && w_fire) w_count_nxt = r_count - c_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sel[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sel_bs <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_fire) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count  <= w_count_nxt;
      r_sel_bs <= (w_count_nxt == c_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left  <= '0;
      r_right <= '0;
    end else begin
      if (w_fire && !w_head)       r_left    <= {1'b1, in_data[W-1:0]};
      else if (r_left[W] && !left_stop)   r_left[W] <= 1'b0;

      if (w_fire && w_head)        r_right   <= {1'b1, in_data[W-1:0]};
      else if (r_right[W] && !right_stop) r_right[W] <= 1'b0;
    end
  end

`ifdef STEER_SPLIT_COUNT_EN
  logic [15:0] r_left_cnt;
  logic [15:0] r_right_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_cnt  <= '0;
      r_right_cnt <= '0;
    end else begin
      if (w_fire && !w_head) r_left_cnt  <= r_left_cnt + 16'd1;
      if (w_fire && w_head)  r_right_cnt <= r_right_cnt + 16'd1;
    end
  end

  assign left_cnt  = r_left_cnt;
  assign right_cnt = r_right_cnt;
`endif

  assign in_back_stop  = w_ibs;
  assign sel_back_stop = r_sel_bs;
  assign left_out      = r_left;
  assign right_out     = r_right;

endmodule

`default_nettype wire

// File: tb/tb_steer_split.sv
// ============================================================================
// tb_steer_split : directed and randomized checks of steer_split against a
// queue-based reference model. Honors STEER_SPLIT_COUNT_EN when defined.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_steer_split;

  localparam int W      = 8;
  localparam int CDEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W:0]   in_data = '0;
  logic [1:0]   sel = '0;
  logic         left_stop = 1'b0;
  logic         right_stop = 1'b0;
  logic         in_back_stop;
  logic         sel_back_stop;
  logic [W:0]   left_out;
  logic [W:0]   right_out;
`ifdef STEER_SPLIT_COUNT_EN
  logic [15:0]  left_cnt;
  logic [15:0]  right_cnt;
`endif

  steer_split #(.W(W), .CDEPTH(CDEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_back_stop (in_back_stop),
    .sel          (sel),
    .sel_back_stop(sel_back_stop),
    .left_out     (left_out),
    .left_stop    (left_stop),
    .right_out    (right_out),
    .right_stop   (right_stop)
`ifdef STEER_SPLIT_COUNT_EN
    ,
    .left_cnt     (left_cnt),
    .right_cnt    (right_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of pending decisions plus the held branch tokens.
  bit          dq[$];
  bit          m_lv, m_rv;
  logic [W-1:0] m_ld, m_rd;
  int          m_lc, m_rc;
  bit          m_push, m_fire;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    m_lv = 0; m_rv = 0; m_ld = '0; m_rd = '0;
    m_lc = 0; m_rc = 0; m_push = 0; m_fire = 0;
  endtask

  task automatic check_and_model();
    bit e_ibs, e_sbs, tgt;
    if (!rst_n) begin
      model_reset();
      chk("rst_left",  16'(left_out),  16'h0);
      chk("rst_right", 16'(right_out), 16'h0);
      chk("rst_ibs",   16'(in_back_stop), 16'h1);
      chk("rst_sbs",   16'(sel_back_stop), 16'h0);
      return;
    end
    e_sbs = (dq.size() == CDEPTH);
    if (dq.size() == 0) e_ibs = 1;
    else begin
      tgt   = dq[0];
      e_ibs = tgt ? (m_rv && right_stop) : (m_lv && left_stop);
    end
    chk("in_back_stop",  16'(in_back_stop),  16'(e_ibs));
    chk("sel_back_stop", 16'(sel_back_stop), 16'(e_sbs));
    chk("left_valid",    16'(left_out[W]),   16'(m_lv));
    chk("right_valid",   16'(right_out[W]),  16'(m_rv));
    if (m_lv) chk("left_data",  16'(left_out[W-1:0]),  16'(m_ld));
    if (m_rv) chk("right_data", 16'(right_out[W-1:0]), 16'(m_rd));
`ifdef STEER_SPLIT_COUNT_EN
    chk("left_cnt",  left_cnt,  16'(m_lc));
    chk("right_cnt", right_cnt, 16'(m_rc));
`endif
    m_fire = in_data[W] && !e_ibs;
    m_push = sel[1] && !e_sbs;
    if (m_lv && !left_stop)  m_lv = 0;
    if (m_rv && !right_stop) m_rv = 0;
    if (m_fire) begin
      tgt = dq.pop_front();
      if (tgt) begin m_rv = 1; m_rd = in_data[W-1:0]; m_rc = (m_rc + 1) % 65536; end
      else     begin m_lv = 1; m_ld = in_data[W-1:0]; m_lc = (m_lc + 1) % 65536; end
    end
    if (m_push) dq.push_back(sel[0]);
  endtask

  // Called at posedge+1: apply inputs, check at negedge, advance to posedge+1.
  task automatic cyc(input logic [1:0] s, input logic [W:0] d, input logic ls, input logic rs);
    sel = s; in_data = d; left_stop = ls; right_stop = rs;
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] r_sel;
    logic [W:0] r_dat;

    model_reset();
    rst_n = 1'b0;
    in_data = 9'h1FF;
    #2;
    chk("reset_left",  16'(left_out),      16'h0);
    chk("reset_right", 16'(right_out),     16'h0);
    chk("reset_ibs",   16'(in_back_stop),  16'h1);
    chk("reset_sbs",   16'(sel_back_stop), 16'h0);
    @(posedge clk); #1;
    cyc(2'b00, 9'h1FF, 0, 0);
    rst_n = 1'b1;
    repeat (3) cyc(2'b00, 9'h1FF, 0, 0);
    chk("idle_no_left",  16'(left_out[W]),  16'h0);
    chk("idle_no_right", 16'(right_out[W]), 16'h0);

    // Basic routing
    cyc(2'b10, 9'h000, 0, 0);
    cyc(2'b11, 9'h000, 0, 0);
    cyc(2'b00, 9'h1A5, 0, 0);
    chk("route_left",  16'(left_out),  16'h1A5);
    cyc(2'b00, 9'h13C, 0, 0);
    chk("route_right", 16'(right_out), 16'h13C);

    // Backpressure on the right branch
    cyc(2'b11, 9'h000, 0, 0);
    cyc(2'b11, 9'h000, 0, 1);
    cyc(2'b00, 9'h155, 0, 1);
    chk("bp_capture", 16'(right_out), 16'h155);
    cyc(2'b00, 9'h1AA, 0, 1);
    chk("bp_stop",    16'(in_back_stop), 16'h1);
    chk("bp_hold",    16'(right_out), 16'h155);
    cyc(2'b00, 9'h1AA, 0, 0);
    chk("bp_next",    16'(right_out), 16'h1AA);

    // FIFO full
    cyc(2'b10, 9'h000, 0, 0);
    cyc(2'b11, 9'h000, 0, 0);
    cyc(2'b10, 9'h000, 0, 0);
    cyc(2'b11, 9'h000, 0, 0);
    chk("full_sbs", 16'(sel_back_stop), 16'h1);
    cyc(2'b11, 9'h000, 0, 0);
    cyc(2'b00, 9'h111, 0, 0);
    chk("full_release", 16'(sel_back_stop), 16'h0);
    cyc(2'b00, 9'h122, 0, 0);
    cyc(2'b00, 9'h133, 0, 0);
    cyc(2'b00, 9'h144, 0, 0);
    cyc(2'b00, 9'h000, 0, 0);

    // Async reset mid-stream
    cyc(2'b10, 9'h000, 0, 0);
    cyc(2'b11, 9'h000, 0, 0);
    cyc(2'b10, 9'h000, 0, 0);
    cyc(2'b10, 9'h177, 1, 0);
    chk("pre_reset_left", 16'(left_out), 16'h177);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_left",  16'(left_out),      16'h0);
    chk("async_right", 16'(right_out),     16'h0);
    chk("async_ibs",   16'(in_back_stop),  16'h1);
    chk("async_sbs",   16'(sel_back_stop), 16'h0);
    model_reset();
    @(posedge clk); #1;
    cyc(2'b00, 9'h1EE, 0, 0);
    rst_n = 1'b1;
    repeat (3) cyc(2'b00, 9'h1EE, 0, 0);
    chk("post_reset_idle", 16'(left_out[W] | right_out[W]), 16'h0);

    // Streaming: alternating L/R, 16 back-to-back tokens
    for (int i = 0; i <= 16; i++) begin
      cyc((i < 16) ? {1'b1, 1'(i % 2)} : 2'b00,
          (i > 0) ? {1'b1, W'(64 + i - 1)} : 9'h000, 0, 0);
    end
    cyc(2'b00, 9'h000, 0, 0);
`ifdef STEER_SPLIT_COUNT_EN
    chk("stream_left_cnt",  left_cnt,  16'd8);
    chk("stream_right_cnt", right_cnt, 16'd8);
`endif

    // Randomized traffic with producers honoring the hold rule
    r_sel = 2'b00;
    r_dat = '0;
    m_push = 0;
    m_fire = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!r_sel[1] || m_push)
        r_sel = ($urandom_range(0, 2) != 0) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
      if (!r_dat[W] || m_fire)
        r_dat = ($urandom_range(0, 3) != 0) ? {1'b1, W'($urandom)} : 9'h000;
      if (k == 1500) rst_n = 1'b0;
      if (k == 1502) rst_n = 1'b1;
      cyc(r_sel, r_dat, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
